// File: rtl/dummy_stream_source_pkg.sv
// Shared definitions for the dummy stream source: FSM encoding and buffer sizing helpers.
package dummy_stream_source_pkg;

   // Controller states: waiting for start, first buffer read in flight, streaming beats.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PRIME  = 2'd1,
      S_STREAM = 2'd2
   } state_e;

   // Number of words held by the preload buffer for a given address width.
   function automatic int depth_of(input int idx_width);
      return 1 << idx_width;
   endfunction

   // Width of the beat-length field: one bit wider than the buffer address so a
   // stream may be longer than the buffer and wrap around it.
   function automatic int len_width_of(input int idx_width);
      return idx_width + 1;
   endfunction

endpackage

// File: rtl/dummy_stream_storage.sv
// Preload buffer: simple dual-port RAM, one write port, one registered read port.
module dummy_stream_storage
   import dummy_stream_source_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Write port and 1-cycle registered read; contents are deliberately never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/dummy_stream_source.sv
// AXI-Stream master that replays a preloaded buffer for a programmed number of beats.
// A RAM word in flight plus a skid entry and the output register give two beats of
// buffering, so TREADY stalls never create bubbles and TVALID is purely registered.
module dummy_stream_source
   import dummy_stream_source_pkg::*;
#(
   parameter int DATA_WIDTH        = 32,
   parameter int STORAGE_IDX_WIDTH = 10,
   parameter int SOURCE_MODE       = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_wr_en,
   input  logic [STORAGE_IDX_WIDTH-1:0] cfg_wr_addr,
   input  logic [DATA_WIDTH-1:0]        cfg_wr_data,
   input  logic                         start,
   input  logic [STORAGE_IDX_WIDTH:0]   length,
   output logic                         busy,
   output logic                         done,
   output logic [DATA_WIDTH-1:0]        M_AXI_TDATA,
   output logic                         M_AXI_TVALID,
   input  logic                         M_AXI_TREADY,
   output logic                         M_AXI_TLAST
);
   localparam int LEN_W   = len_width_of(STORAGE_IDX_WIDTH);
   localparam bit MODE_ON = (SOURCE_MODE != 0);

   state_e                       state_q, state_d;
   logic [LEN_W-1:0]             len_q, len_d;
   logic [LEN_W-1:0]             issue_cnt_q, issue_cnt_d;
   logic [STORAGE_IDX_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                         pend_q, pend_d;
   logic                         pend_last_q, pend_last_d;
   logic                         skid_vld_q, skid_vld_d;
   logic                         skid_last_q, skid_last_d;
   logic [DATA_WIDTH-1:0]        skid_data_q, skid_data_d;
   logic                         out_vld_q, out_vld_d;
   logic                         out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
   logic                         done_q, done_d;

   logic                         idle;
   logic                         start_go;
   logic                         pop;
   logic                         final_pop;
   logic                         can_issue;
   logic [1:0]                   occ;
   logic                         ram_wr_en;
   logic                         ram_rd_en;
   logic [STORAGE_IDX_WIDTH-1:0] ram_rd_addr;
   logic [DATA_WIDTH-1:0]        ram_rd_data;

   // An inactive instance (SOURCE_MODE=0) never launches and never writes the buffer.
   assign idle      = (state_q == S_IDLE);
   assign start_go  = MODE_ON && idle && start && (length != '0);
   assign ram_wr_en = MODE_ON && idle && cfg_wr_en;
   assign pop       = out_vld_q && M_AXI_TREADY;
   assign final_pop = pop && out_last_q;

   dummy_stream_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (STORAGE_IDX_WIDTH)
   ) u_storage (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (cfg_wr_addr),
      .wr_data (cfg_wr_data),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data)
   );

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         issue_cnt_q <= '0;
         rd_addr_q   <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         skid_vld_q  <= 1'b0;
         skid_last_q <= 1'b0;
         skid_data_q <= '0;
         out_vld_q   <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         rd_addr_q   <= rd_addr_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         skid_vld_q  <= skid_vld_d;
         skid_last_q <= skid_last_d;
         skid_data_q <= skid_data_d;
         out_vld_q   <= out_vld_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
      end
   end

   // Next-state logic: launch on start, one priming cycle, stream until the TLAST handshake.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start_go) state_d = S_PRIME;
         S_PRIME:  state_d = S_STREAM;
         S_STREAM: if (final_pop) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Read issue: keep at most two beats buffered (output + skid, counting the RAM word in flight).
   always_comb begin
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      rd_addr_d   = rd_addr_q;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      ram_rd_en   = 1'b0;
      ram_rd_addr = rd_addr_q;
      can_issue   = 1'b0;
      occ         = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(pend_q) - 2'(pop);
      if (start_go) begin
         len_d       = length;
         issue_cnt_d = LEN_W'(1);
         rd_addr_d   = STORAGE_IDX_WIDTH'(1);
         ram_rd_en   = 1'b1;
         ram_rd_addr = '0;
         pend_d      = 1'b1;
         pend_last_d = (length == LEN_W'(1));
      end else if (!idle && !final_pop) begin
         can_issue = (issue_cnt_q != len_q) && (occ < 2'd2);
         if (can_issue) begin
            ram_rd_en   = 1'b1;
            pend_d      = 1'b1;
            pend_last_d = (issue_cnt_q == len_q - 1'b1);
            rd_addr_d   = rd_addr_q + 1'b1;
            issue_cnt_d = issue_cnt_q + 1'b1;
         end
      end
   end

   // Output register and skid: refill the output from skid first, then from the RAM word.
   always_comb begin
      skid_vld_d  = skid_vld_q;
      skid_last_d = skid_last_q;
      skid_data_d = skid_data_q;
      out_vld_d   = out_vld_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      done_d      = final_pop;
      if (final_pop) begin
         out_vld_d   = 1'b0;
         out_last_d  = 1'b0;
         skid_vld_d  = 1'b0;
         skid_last_d = 1'b0;
      end else if (!out_vld_q || pop) begin
         if (skid_vld_q) begin
            out_vld_d   = 1'b1;
            out_data_d  = skid_data_q;
            out_last_d  = skid_last_q;
            skid_vld_d  = pend_q;
            skid_data_d = ram_rd_data;
            skid_last_d = pend_last_q;
         end else if (pend_q) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_rd_data;
            out_last_d = pend_last_q;
         end else begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
         end
      end else if (pend_q) begin
         skid_vld_d  = 1'b1;
         skid_data_d = ram_rd_data;
         skid_last_d = pend_last_q;
      end
   end

   // Outputs are driven straight from registers.
   always_comb begin
      busy         = !idle;
      done         = done_q;
      M_AXI_TDATA  = out_data_q;
      M_AXI_TVALID = out_vld_q;
      M_AXI_TLAST  = out_last_q;
   end

endmodule

// File: tb/tb_dummy_stream_source.sv
// Self-checking bench for dummy_stream_source with an 8-word buffer so streams wrap.
module tb_dummy_stream_source;
   localparam int DW = 32;
   localparam int IW = 3;
   localparam int LW = IW + 1;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_wr_en;
   logic [IW-1:0] cfg_wr_addr;
   logic [DW-1:0] cfg_wr_data;
   logic          start;
   logic [LW-1:0] length;
   logic          M_AXI_TREADY;

   logic          busy, done, M_AXI_TVALID, M_AXI_TLAST;
   logic [DW-1:0] M_AXI_TDATA;
   logic          off_busy, off_done, off_tvalid, off_tlast;
   logic [DW-1:0] off_tdata;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model of the buffer contents: beat k of a stream carries model_mem[k mod 8].
   logic [DW-1:0] model_mem [D];

   always #5 clk = ~clk;

   dummy_stream_source #(
      .DATA_WIDTH        (DW),
      .STORAGE_IDX_WIDTH (IW),
      .SOURCE_MODE       (1)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_wr_en    (cfg_wr_en),
      .cfg_wr_addr  (cfg_wr_addr),
      .cfg_wr_data  (cfg_wr_data),
      .start        (start),
      .length       (length),
      .busy         (busy),
      .done         (done),
      .M_AXI_TDATA  (M_AXI_TDATA),
      .M_AXI_TVALID (M_AXI_TVALID),
      .M_AXI_TREADY (M_AXI_TREADY),
      .M_AXI_TLAST  (M_AXI_TLAST)
   );

   dummy_stream_source #(
      .DATA_WIDTH        (DW),
      .STORAGE_IDX_WIDTH (IW),
      .SOURCE_MODE       (0)
   ) u_off (
      .clk          (clk),
      .reset        (reset),
      .cfg_wr_en    (cfg_wr_en),
      .cfg_wr_addr  (cfg_wr_addr),
      .cfg_wr_data  (cfg_wr_data),
      .start        (start),
      .length       (length),
      .busy         (off_busy),
      .done         (off_done),
      .M_AXI_TDATA  (off_tdata),
      .M_AXI_TVALID (off_tvalid),
      .M_AXI_TREADY (M_AXI_TREADY),
      .M_AXI_TLAST  (off_tlast)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // TREADY pattern: 0 = always ready, 1 = repeating 1,0,0,1, otherwise random.
   function automatic bit ready_of(input int rmode, input int cyc);
      if (rmode == 0) return 1'b1;
      if (rmode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      return ($urandom_range(0, 1) == 1);
   endfunction

   task automatic write_word(input int addr, input logic [DW-1:0] data);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = IW'(addr);
      cfg_wr_data = data;
      tick();
      cfg_wr_en   = 1'b0;
      model_mem[addr] = data;
   endtask

   // Pulse start for one edge; busy must rise right after it while TVALID is still low.
   task automatic start_stream(input int len);
      start  = 1'b1;
      length = LW'(len);
      tick();
      start  = 1'b0;
      length = '0;
      check("launch_busy", 32'(busy), 32'd1);
      check("launch_tvalid", 32'(M_AXI_TVALID), 32'd0);
      check("launch_done", 32'(done), 32'd0);
   endtask

   // Consume a launched stream, checking every beat against the model; ends one cycle after
   // the final handshake with done expected high.
   task automatic collect(input int len, input int rmode, input bit mid_start, input bit mid_wr,
                          input string name);
      int            beat;
      int            cyc;
      int            budget;
      bit            hs;
      bit            stalled;
      logic [DW-1:0] prev_d;
      logic          prev_l;
      beat    = 0;
      cyc     = 0;
      budget  = 8 * len + 32;
      stalled = 1'b0;
      prev_d  = '0;
      prev_l  = 1'b0;
      M_AXI_TREADY = 1'b1;
      tick();
      while (beat < len && cyc < budget) begin
         check({name, "_tvalid"}, 32'(M_AXI_TVALID), 32'd1);
         check({name, "_tdata"}, M_AXI_TDATA, model_mem[beat[2:0]]);
         check({name, "_tlast"}, 32'(M_AXI_TLAST), 32'(beat == len - 1));
         check({name, "_busy"}, 32'(busy), 32'd1);
         if (stalled) begin
            check({name, "_stall_tdata"}, M_AXI_TDATA, prev_d);
            check({name, "_stall_tlast"}, 32'(M_AXI_TLAST), 32'(prev_l));
         end
         M_AXI_TREADY = ready_of(rmode, cyc);
         hs      = M_AXI_TVALID && M_AXI_TREADY;
         stalled = !hs;
         prev_d  = M_AXI_TDATA;
         prev_l  = M_AXI_TLAST;
         if (mid_start && cyc == 2) begin
            start  = 1'b1;
            length = LW'(3);
         end
         if (mid_wr && cyc == 1) begin
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = IW'(D - 1);
            cfg_wr_data = 32'hDEAD_BEEF;
         end
         tick();
         start     = 1'b0;
         length    = '0;
         cfg_wr_en = 1'b0;
         if (hs) beat++;
         cyc++;
      end
      check({name, "_beats"}, 32'(beat), 32'(len));
      check({name, "_end_tvalid"}, 32'(M_AXI_TVALID), 32'd0);
      check({name, "_end_tlast"}, 32'(M_AXI_TLAST), 32'd0);
      check({name, "_end_busy"}, 32'(busy), 32'd0);
      check({name, "_end_done"}, 32'(done), 32'd1);
      $display("[TB] stream %s len=%0d beats=%0d cycles=%0d", name, len, beat, cyc);
   endtask

   task automatic idle_after();
      tick();
      check("done_clear", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int len;
      reset        = 1'b1;
      cfg_wr_en    = 1'b0;
      cfg_wr_addr  = '0;
      cfg_wr_data  = '0;
      start        = 1'b0;
      length       = '0;
      M_AXI_TREADY = 1'b0;
      repeat (3) tick();

      check("rst_tvalid", 32'(M_AXI_TVALID), 32'd0);
      check("rst_tlast", 32'(M_AXI_TLAST), 32'd0);
      check("rst_tdata", M_AXI_TDATA, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_off_tvalid", 32'(off_tvalid), 32'd0);
      check("rst_off_busy", 32'(off_busy), 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < D; i++) write_word(i, 32'h100 + 32'(i));

      // Full buffer at full rate, then a second stream started on the cycle done is high.
      start_stream(8);
      collect(8, 0, 1'b0, 1'b0, "basic");
      start_stream(8);
      collect(8, 1, 1'b0, 1'b0, "toggle");
      idle_after();

      start_stream(10);
      collect(10, 0, 1'b0, 1'b0, "wrap");
      idle_after();

      start_stream(1);
      collect(1, 0, 1'b0, 1'b0, "len1");
      idle_after();

      // Zero length: nothing happens at all.
      start  = 1'b1;
      length = '0;
      tick();
      start  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("len0_busy", 32'(busy), 32'd0);
         check("len0_tvalid", 32'(M_AXI_TVALID), 32'd0);
         check("len0_done", 32'(done), 32'd0);
         tick();
      end
      $display("[TB] stream len0 ignored");

      start_stream(8);
      collect(8, 0, 1'b1, 1'b0, "midstart");
      idle_after();

      start_stream(8);
      collect(8, 2, 1'b0, 1'b1, "midwr");
      idle_after();

      start_stream(15);
      collect(15, 2, 1'b0, 1'b0, "maxlen");
      idle_after();

      // Reset while beat 3 is on the bus.
      start_stream(8);
      M_AXI_TREADY = 1'b1;
      repeat (4) tick();
      check("rst_mid_beat3", M_AXI_TDATA, model_mem[3]);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_tvalid", 32'(M_AXI_TVALID), 32'd0);
      check("rst_mid_tlast", 32'(M_AXI_TLAST), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      check("rst_mid_tdata", M_AXI_TDATA, 32'd0);
      $display("[TB] reset mid-stream");
      start_stream(8);
      collect(8, 0, 1'b0, 1'b0, "after_rst");
      idle_after();

      // Randomized contents, lengths and backpressure.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < D; i++) write_word(i, $urandom);
         len = int'($urandom_range(1, 15));
         start_stream(len);
         collect(len, 2, 1'b0, 1'b0, "rand");
         idle_after();
      end

      // Inactive instance stays silent despite starts, writes and ready.
      M_AXI_TREADY = 1'b1;
      for (int i = 0; i < 100; i++) begin
         start       = ((i % 5) == 0);
         length      = LW'(4);
         cfg_wr_en   = ((i % 7) == 3);
         cfg_wr_addr = IW'(i);
         cfg_wr_data = $urandom;
         tick();
         check("off_tvalid", 32'(off_tvalid), 32'd0);
         check("off_tlast", 32'(off_tlast), 32'd0);
         check("off_busy", 32'(off_busy), 32'd0);
         check("off_done", 32'(off_done), 32'd0);
         check("off_tdata", off_tdata, 32'd0);
      end
      start     = 1'b0;
      cfg_wr_en = 1'b0;
      $display("[TB] inactive instance silent for 100 cycles");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
